// File: rtl/writeback_unit_pkg.sv
// Shared constants, encodings and types for the X->W writeback slice of the RV32I core.
package writeback_unit_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [11:0] TOHOST_A = 12'h51E;

    typedef enum logic [1:0] {
        WB_MEM = 2'd0,
        WB_ALU = 2'd1,
        WB_PC4 = 2'd2,
        WB_RSV = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RS1  = 2'd1,
        CSR_ZIMM = 2'd2,
        CSR_RSV  = 2'd3
    } csr_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rs1;
    } w_reg_t;

    function automatic logic csr_sel_writes(input logic [1:0] sel);
        return (sel == CSR_RS1) || (sel == CSR_ZIMM);
    endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// X-stage operands, StageW decode and writeback results exchanged with the writeback unit.
interface writeback_unit_if;
    import writeback_unit_pkg::*;

    logic [XLEN-1:0] inst_X;
    logic [XLEN-1:0] pc_X;
    logic [XLEN-1:0] alu_X;
    logic [XLEN-1:0] rs1_X;
    logic [XLEN-1:0] dmem_dout;
    logic [1:0]      WBSel;
    logic            RegWEn;
    logic [1:0]      CSRSel;

    logic [XLEN-1:0] inst_W;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            wb_en;

    modport master (
        output inst_X, pc_X, alu_X, rs1_X, dmem_dout, WBSel, RegWEn, CSRSel,
        input  inst_W, wb_addr, wb_data, wb_en
    );

    modport slave (
        input  inst_X, pc_X, alu_X, rs1_X, dmem_dout, WBSel, RegWEn, CSRSel,
        output inst_W, wb_addr, wb_data, wb_en
    );

endinterface

// File: rtl/writeback_unit_load_extract.sv
// Picks the addressed byte/halfword out of a DMEM word and extends it per the load funct3.
module load_extract
    import writeback_unit_pkg::*;
(
    input  logic [XLEN-1:0] dout,
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] value
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = dout[7:0];
        case (off)
            2'd0: byte_v = dout[7:0];
            2'd1: byte_v = dout[15:8];
            2'd2: byte_v = dout[23:16];
            2'd3: byte_v = dout[31:24];
            default: byte_v = dout[7:0];
        endcase
    end

    // Halfword loads are assumed aligned, so only off[1] selects.
    assign half_v = off[1] ? dout[31:16] : dout[15:0];

    always_comb begin
        value = dout;
        case (funct3)
            F3_LB:   value = {{24{byte_v[7]}}, byte_v};
            F3_LBU:  value = {24'b0, byte_v};
            F3_LH:   value = {{16{half_v[15]}}, half_v};
            F3_LHU:  value = {16'b0, half_v};
            F3_LW:   value = dout;
            default: value = dout;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// X->W pipeline register, writeback mux, tohost CSR and cycle/instret counters.
module writeback_unit
    import writeback_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    writeback_unit_if.slave  wb,
    output logic [XLEN-1:0]  tohost,
    output logic             tohost_vld,
    output logic [XLEN-1:0]  cycle_cnt,
    output logic [XLEN-1:0]  instret
);

    w_reg_t          w_q;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] wb_data_c;
    logic [XLEN-1:0] csr_val;
    logic            csr_we;
    logic            retire;

    // Flush beats stall so a redirect can never be held in W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            w_q <= '{inst: NOP_INST, pc: '0, alu: '0, rs1: '0};
        else if (flush)
            w_q <= '{inst: NOP_INST, pc: '0, alu: '0, rs1: '0};
        else if (!stall)
            w_q <= '{inst: wb.inst_X, pc: wb.pc_X, alu: wb.alu_X, rs1: wb.rs1_X};
    end

    load_extract u_load_extract (
        .dout   (wb.dmem_dout),
        .funct3 (w_q.inst[14:12]),
        .off    (w_q.alu[1:0]),
        .value  (load_val)
    );

    always_comb begin
        wb_data_c = '0;
        case (wb.WBSel)
            WB_MEM:  wb_data_c = load_val;
            WB_ALU:  wb_data_c = w_q.alu;
            WB_PC4:  wb_data_c = w_q.pc + 32'd4;
            default: wb_data_c = '0;
        endcase
    end

    assign wb.inst_W  = w_q.inst;
    assign wb.wb_addr = w_q.inst[11:7];
    assign wb.wb_data = wb_data_c;
    assign wb.wb_en   = wb.RegWEn && (w_q.inst[11:7] != 5'd0);

    // A stalled CSR op writes only on the edge it actually leaves W.
    assign csr_we  = csr_sel_writes(wb.CSRSel) && (w_q.inst[31:20] == TOHOST_A) && !stall;
    assign csr_val = (wb.CSRSel == CSR_RS1) ? w_q.rs1 : {27'b0, w_q.inst[19:15]};
    assign retire  = !stall && (w_q.inst != NOP_INST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tohost     <= '0;
            tohost_vld <= 1'b0;
        end else begin
            tohost_vld <= csr_we;
            if (csr_we)
                tohost <= csr_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instret   <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (retire)
                instret <= instret + 32'd1;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed checks of the writeback unit: reset, loads, writeback mux, tohost CSR, stall/flush, counters.
module tb_writeback_unit;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] ADDI5   = 32'h0010_0293;  // addi x5,x0,1
    localparam logic [31:0] ADDI7   = 32'h0010_0393;  // addi x7,x0,1
    localparam logic [31:0] ADDI0   = 32'h0010_0013;  // addi x0,x0,1
    localparam logic [31:0] JAL1    = 32'h0080_00EF;  // jal x1,8
    localparam logic [31:0] LB6     = 32'h0000_0303;
    localparam logic [31:0] LH6     = 32'h0000_1303;
    localparam logic [31:0] LW6     = 32'h0000_2303;
    localparam logic [31:0] LD6     = 32'h0000_3303;  // funct3=3, not a RV32I load
    localparam logic [31:0] LBU6    = 32'h0000_4303;
    localparam logic [31:0] LHU6    = 32'h0000_5303;
    localparam logic [31:0] CSRWI_T = 32'h51E2_D073;  // csrrwi x0,0x51E,5
    localparam logic [31:0] CSRW_M  = 32'h3000_9073;  // csrrw x0,0x300,x1
    localparam logic [31:0] CSRW_T  = 32'h51E0_9073;  // csrrw x0,0x51E,x1
    localparam logic [31:0] DMEM    = 32'h80F0_7F01;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] tohost;
    logic        tohost_vld;
    logic [31:0] cycle_cnt;
    logic [31:0] instret;

    int n_cmp = 0;
    int n_bad = 0;
    int tcount = 0;

    writeback_unit_if bus ();

    writeback_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .wb         (bus.slave),
        .tohost     (tohost),
        .tohost_vld (tohost_vld),
        .cycle_cnt  (cycle_cnt),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        tcount++;
    endtask

    task automatic set_x(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] rs1);
        bus.inst_X = inst;
        bus.pc_X   = pc;
        bus.alu_X  = alu;
        bus.rs1_X  = rs1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tcount = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        set_x(NOP, 0, 0, 0);
        bus.dmem_dout = '0;
        bus.WBSel = 2'd1;
        bus.RegWEn = 1'b0;
        bus.CSRSel = 2'd0;
        tick();
        tick();
        n_cmp++; if (bus.inst_W !== NOP) begin n_bad++; $display("FAIL reset_inst got %h want %h", bus.inst_W, NOP); end
        n_cmp++; if (tohost !== 32'h0 || tohost_vld !== 1'b0) begin n_bad++; $display("FAIL reset_tohost got %h/%b want 0/0", tohost, tohost_vld); end
        n_cmp++; if (cycle_cnt !== 32'h0 || instret !== 32'h0) begin n_bad++; $display("FAIL reset_cnt got %h/%h want 0/0", cycle_cnt, instret); end
        rst_n = 1'b1;
        tcount = 0;
        tick(); tick(); tick();
        n_cmp++; if (cycle_cnt !== 32'd3 || instret !== 32'd0) begin n_bad++; $display("FAIL cnt_after_reset got %0d/%0d want 3/0", cycle_cnt, instret); end
    endtask

    task automatic test_loads();
        bus.dmem_dout = DMEM;
        bus.WBSel = 2'd0;
        bus.RegWEn = 1'b1;
        set_x(LB6, 0, 32'h0000_2003, 0); tick();
        n_cmp++; if (bus.wb_data !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_off3 got %h want ffffff80", bus.wb_data); end
        n_cmp++; if (bus.wb_addr !== 5'd6 || bus.wb_en !== 1'b1) begin n_bad++; $display("FAIL load_rd got %0d/%b want 6/1", bus.wb_addr, bus.wb_en); end
        set_x(LBU6, 0, 32'h0000_2001, 0); tick();
        n_cmp++; if (bus.wb_data !== 32'h0000_007F) begin n_bad++; $display("FAIL lbu_off1 got %h want 0000007f", bus.wb_data); end
        set_x(LH6, 0, 32'h0000_2002, 0); tick();
        n_cmp++; if (bus.wb_data !== 32'hFFFF_80F0) begin n_bad++; $display("FAIL lh_off2 got %h want ffff80f0", bus.wb_data); end
        set_x(LH6, 0, 32'h0000_2001, 0); tick();
        n_cmp++; if (bus.wb_data !== 32'h0000_7F01) begin n_bad++; $display("FAIL lh_off1 got %h want 00007f01", bus.wb_data); end
        set_x(LHU6, 0, 32'h0000_2003, 0); tick();
        n_cmp++; if (bus.wb_data !== 32'h0000_80F0) begin n_bad++; $display("FAIL lhu_off3 got %h want 000080f0", bus.wb_data); end
        set_x(LW6, 0, 32'h0000_2000, 0); tick();
        n_cmp++; if (bus.wb_data !== DMEM) begin n_bad++; $display("FAIL lw got %h want %h", bus.wb_data, DMEM); end
        set_x(LD6, 0, 32'h0000_2001, 0); tick();
        n_cmp++; if (bus.wb_data !== DMEM) begin n_bad++; $display("FAIL f3_other got %h want %h", bus.wb_data, DMEM); end
        set_x(LB6, 0, 32'h0000_2000, 0); tick();
        n_cmp++; if (bus.wb_data !== 32'h0000_0001) begin n_bad++; $display("FAIL lb_off0 got %h want 00000001", bus.wb_data); end
    endtask

    task automatic test_writeback();
        bus.RegWEn = 1'b1;
        bus.WBSel = 2'd2;
        set_x(JAL1, 32'h0000_1000, 32'h0000_1234, 0); tick();
        n_cmp++; if (bus.wb_data !== 32'h0000_1004) begin n_bad++; $display("FAIL jal_pc4 got %h want 00001004", bus.wb_data); end
        n_cmp++; if (bus.wb_addr !== 5'd1 || bus.wb_en !== 1'b1) begin n_bad++; $display("FAIL jal_rd got %0d/%b want 1/1", bus.wb_addr, bus.wb_en); end
        bus.WBSel = 2'd1; #1;
        n_cmp++; if (bus.wb_data !== 32'h0000_1234) begin n_bad++; $display("FAIL sel_alu got %h want 00001234", bus.wb_data); end
        bus.WBSel = 2'd3; #1;
        n_cmp++; if (bus.wb_data !== 32'h0) begin n_bad++; $display("FAIL sel_rsv got %h want 0", bus.wb_data); end
        bus.WBSel = 2'd2;
        set_x(JAL1, 32'hFFFF_FFFC, 0, 0); tick();
        n_cmp++; if (bus.wb_data !== 32'h0) begin n_bad++; $display("FAIL pc4_wrap got %h want 0", bus.wb_data); end
        bus.WBSel = 2'd1;
        set_x(ADDI0, 0, 32'h1, 0); tick();
        n_cmp++; if (bus.wb_en !== 1'b0) begin n_bad++; $display("FAIL rd_x0 got %b want 0", bus.wb_en); end
        set_x(ADDI5, 0, 32'h1, 0); tick();
        bus.RegWEn = 1'b0; #1;
        n_cmp++; if (bus.wb_en !== 1'b0) begin n_bad++; $display("FAIL regwen_off got %b want 0", bus.wb_en); end
        bus.RegWEn = 1'b1; #1;
        n_cmp++; if (bus.wb_en !== 1'b1 || bus.wb_addr !== 5'd5) begin n_bad++; $display("FAIL regwen_on got %b/%0d want 1/5", bus.wb_en, bus.wb_addr); end
        bus.RegWEn = 1'b0;
    endtask

    task automatic test_csr();
        do_reset();
        bus.CSRSel = 2'd0;
        set_x(CSRWI_T, 0, 0, 0); tick();
        bus.CSRSel = 2'd2; #1;
        n_cmp++; if (tohost !== 32'h0 || tohost_vld !== 1'b0) begin n_bad++; $display("FAIL csrwi_pre got %h/%b want 0/0", tohost, tohost_vld); end
        set_x(NOP, 0, 0, 0); tick();
        bus.CSRSel = 2'd0;
        n_cmp++; if (tohost !== 32'h5 || tohost_vld !== 1'b1) begin n_bad++; $display("FAIL csrwi_wr got %h/%b want 5/1", tohost, tohost_vld); end
        tick();
        n_cmp++; if (tohost_vld !== 1'b0) begin n_bad++; $display("FAIL vld_pulse got %b want 0", tohost_vld); end
        set_x(CSRW_M, 0, 0, 32'h0000_AAAA); tick();
        bus.CSRSel = 2'd1;
        set_x(NOP, 0, 0, 0); tick();
        bus.CSRSel = 2'd0;
        n_cmp++; if (tohost !== 32'h5 || tohost_vld !== 1'b0) begin n_bad++; $display("FAIL csr_other got %h/%b want 5/0", tohost, tohost_vld); end
        set_x(CSRW_T, 0, 0, 32'h1111_2222); tick();
        bus.CSRSel = 2'd3;
        set_x(NOP, 0, 0, 0); tick();
        bus.CSRSel = 2'd0;
        n_cmp++; if (tohost !== 32'h5 || tohost_vld !== 1'b0) begin n_bad++; $display("FAIL csr_rsv got %h/%b want 5/0", tohost, tohost_vld); end
        set_x(CSRW_T, 0, 0, 32'hDEAD_BEEF); tick();
        bus.CSRSel = 2'd1;
        stall = 1'b1;
        set_x(NOP, 0, 0, 0);
        tick(); tick();
        n_cmp++; if (tohost !== 32'h5 || tohost_vld !== 1'b0) begin n_bad++; $display("FAIL csr_stall got %h/%b want 5/0", tohost, tohost_vld); end
        stall = 1'b0; tick();
        bus.CSRSel = 2'd0;
        n_cmp++; if (tohost !== 32'hDEAD_BEEF || tohost_vld !== 1'b1) begin n_bad++; $display("FAIL csr_after_stall got %h/%b want deadbeef/1", tohost, tohost_vld); end
        tick();
        n_cmp++; if (tohost !== 32'hDEAD_BEEF || tohost_vld !== 1'b0) begin n_bad++; $display("FAIL csr_single got %h/%b want deadbeef/0", tohost, tohost_vld); end
    endtask

    task automatic test_stall_flush();
        do_reset();
        set_x(ADDI5, 0, 0, 0); tick();
        n_cmp++; if (bus.inst_W !== ADDI5 || instret !== 32'd0) begin n_bad++; $display("FAIL load_w got %h/%0d want %h/0", bus.inst_W, instret, ADDI5); end
        stall = 1'b1;
        set_x(ADDI7, 0, 0, 0);
        tick(); tick(); tick();
        n_cmp++; if (bus.inst_W !== ADDI5 || instret !== 32'd0) begin n_bad++; $display("FAIL stall_hold got %h/%0d want %h/0", bus.inst_W, instret, ADDI5); end
        stall = 1'b0;
        set_x(NOP, 0, 0, 0); tick();
        n_cmp++; if (instret !== 32'd1 || bus.inst_W !== NOP) begin n_bad++; $display("FAIL stall_retire got %0d/%h want 1/%h", instret, bus.inst_W, NOP); end
        tick();
        n_cmp++; if (instret !== 32'd1) begin n_bad++; $display("FAIL bubble_no_ret got %0d want 1", instret); end
        set_x(ADDI5, 0, 0, 0); tick();
        stall = 1'b1; flush = 1'b1; tick();
        n_cmp++; if (bus.inst_W !== NOP || instret !== 32'd1) begin n_bad++; $display("FAIL stall_flush got %h/%0d want %h/1", bus.inst_W, instret, NOP); end
        stall = 1'b0; flush = 1'b0; tick();
        flush = 1'b1; tick();
        n_cmp++; if (bus.inst_W !== NOP || instret !== 32'd2) begin n_bad++; $display("FAIL flush got %h/%0d want %h/2", bus.inst_W, instret, NOP); end
        flush = 1'b0;
        set_x(NOP, 0, 0, 0); tick();
        n_cmp++; if (instret !== 32'd2 || cycle_cnt !== tcount) begin n_bad++; $display("FAIL cnt_sum got %0d/%0d want 2/%0d", instret, cycle_cnt, tcount); end
    endtask

    task automatic test_counter_wrap();
        set_x(ADDI5, 0, 0, 0); tick();
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        release dut.instret;
        #1;
        n_cmp++; if (cycle_cnt !== 32'hFFFF_FFFF || instret !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL preload got %h/%h want ffffffff/ffffffff", cycle_cnt, instret); end
        set_x(NOP, 0, 0, 0); tick();
        n_cmp++; if (cycle_cnt !== 32'h0 || instret !== 32'h0) begin n_bad++; $display("FAIL wrap got %h/%h want 0/0", cycle_cnt, instret); end
    endtask

    task automatic test_reset_mid();
        bus.CSRSel = 2'd0;
        set_x(CSRWI_T, 0, 0, 0); tick();
        bus.CSRSel = 2'd2;
        set_x(ADDI5, 0, 0, 0); tick();
        bus.CSRSel = 2'd0;
        n_cmp++; if (tohost !== 32'h5 || bus.inst_W !== ADDI5) begin n_bad++; $display("FAIL mid_setup got %h/%h want 5/%h", tohost, bus.inst_W, ADDI5); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.inst_W !== NOP || tohost !== 32'h0 || tohost_vld !== 1'b0) begin n_bad++; $display("FAIL mid_reset got %h/%h/%b want %h/0/0", bus.inst_W, tohost, tohost_vld, NOP); end
        n_cmp++; if (cycle_cnt !== 32'h0 || instret !== 32'h0) begin n_bad++; $display("FAIL mid_reset_cnt got %h/%h want 0/0", cycle_cnt, instret); end
        tick();
        rst_n = 1'b1;
        set_x(NOP, 0, 0, 0); tick();
        n_cmp++; if (instret !== 32'h0 || cycle_cnt !== 32'd1) begin n_bad++; $display("FAIL mid_no_retire got %0d/%0d want 0/1", instret, cycle_cnt); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_writeback();
        test_csr();
        test_stall_flush();
        test_counter_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
